// File: rtl/mxv_result_drain_if.sv
// Result-side stream bundle of the MxV datapath: result words in, drained words out
// with index and end-of-job markers.
interface mxv_result_drain_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 3
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              out_last;
   logic              pre_last;
   logic [LEN_W-1:0]  out_idx;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, pre_last, out_idx
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, pre_last, out_idx
   );
endinterface

// File: rtl/mxv_result_drain.sv
// Collects the len results of one MxV job into a small FIFO and drains them onto a
// valid/ready stream with index, last/pre-last markers and an end-of-job pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | accepting results and draining them downstream
// DONE  | one-cycle end-of-job pulse, then back to IDLE
module mxv_result_drain #(
   parameter int DATA_W  = 16,
   parameter int MAX_LEN = 7,
   parameter int LEN_W   = 3,
   parameter int DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sys_rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   mxv_result_drain_if.slave bus,
   output logic              busy,
   output logic              done
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [LEN_W-1:0]  len_q, in_cnt, out_cnt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push, pop, fifo_full, fifo_empty, last_hit, pre_hit;
   logic [LEN_W:0]    len_m3;

   assign fifo_full     = (fifo_cnt == CNT_W'(DEPTH));
   assign fifo_empty    = (fifo_cnt == '0);
   assign bus.in_ready  = (state == RUN) && !fifo_full && (in_cnt < len_q);
   assign bus.out_valid = (state == RUN) && !fifo_empty;
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   // len-3 carries a sign bit so short jobs go negative instead of wrapping onto an index
   assign len_m3   = {1'b0, len_q} - (LEN_W+1)'(3);
   assign pre_hit  = !len_m3[LEN_W] && (len_m3 == {1'b0, out_cnt});
   assign last_hit = (out_cnt == len_q - LEN_W'(1));

   assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.out_idx  = out_cnt;
   assign bus.out_last = bus.out_valid && last_hit;
   assign bus.pre_last = bus.out_valid && pre_hit;

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
         RUN:     if (pop && last_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         len_q    <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (sys_rst) begin
         state    <= IDLE;
         len_q    <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            len_q   <= len;
            in_cnt  <= '0;
            out_cnt <= '0;
         end
         if (state == DONE) begin
            in_cnt  <= '0;
            out_cnt <= '0;
         end
         if (push) begin
            in_cnt <= in_cnt + LEN_W'(1);
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            out_cnt <= out_cnt + LEN_W'(1);
            rd_ptr  <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
   end

   // Storage needs no reset: out_data is gated to zero while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   generate
      if (MAX_LEN < (1 << LEN_W) - 1) begin : g_len_chk
         always_ff @(posedge clk) begin
            if (reset && !sys_rst && state == IDLE && start)
               assert (int'(len) <= MAX_LEN);
         end
      end
   endgenerate
endmodule

// File: tb/tb_mxv_result_drain.sv
// Directed bench for mxv_result_drain: streaming, FIFO stall, zero/short jobs,
// sync flush, ignored restart and async reset.
module tb_mxv_result_drain;
   logic       clk, reset, sys_rst, start;
   logic [2:0] len;
   logic       busy, done;
   int         total, bad, acc, got;
   bit         seen_done;

   mxv_result_drain_if #(.DATA_W(16), .LEN_W(3)) bus ();

   mxv_result_drain #(.DATA_W(16), .MAX_LEN(7), .LEN_W(3), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .sys_rst(sys_rst), .start(start), .len(len),
      .bus(bus), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_out_data"},  32'(bus.out_data),  0);
      chk({tag, "_out_last"},  32'(bus.out_last),  0);
      chk({tag, "_pre_last"},  32'(bus.pre_last),  0);
      chk({tag, "_out_idx"},   32'(bus.out_idx),   0);
      chk({tag, "_busy"},      32'(busy),          0);
      chk({tag, "_done"},      32'(done),          0);
   endtask

   // Called at a negedge in RUN with nothing pushed yet; streams n words with out_ready=1
   task automatic stream(input int n, input logic [15:0] base, input logic [15:0] stp, input int l);
      bus.in_valid  = 1'b1;
      bus.in_data   = base;
      bus.out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         nclk();
         chk("s_valid", 32'(bus.out_valid), 1);
         chk("s_data",  32'(bus.out_data),  32'(base + 16'(i) * stp));
         chk("s_idx",   32'(bus.out_idx),   32'(i));
         chk("s_pre",   32'(bus.pre_last),  32'(i == l - 3));
         chk("s_last",  32'(bus.out_last),  32'(i == l - 1));
         bus.in_data = base + 16'(i + 1) * stp;
         if (i == n - 1) bus.in_valid = 1'b0;
      end
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b0; sys_rst = 1'b0; start = 1'b0; len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      nclk();
      chk_zero("reset");
      reset = 1'b1;
      nclk();

      // len=5 back-to-back stream
      start = 1'b1; len = 3'd5;
      nclk();
      start = 1'b0;
      chk("t1_busy", 32'(busy), 1);
      chk("t1_in_ready", 32'(bus.in_ready), 1);
      chk("t1_out_valid0", 32'(bus.out_valid), 0);
      stream(5, 16'h0011, 16'h0011, 5);
      chk("t1_in_ready_end", 32'(bus.in_ready), 0);
      nclk();
      chk("t1_done", 32'(done), 1);
      chk("t1_busy_done", 32'(busy), 1);
      chk("t1_valid_done", 32'(bus.out_valid), 0);
      nclk();
      chk("t1_done_off", 32'(done), 0);
      chk("t1_busy_off", 32'(busy), 0);

      // len=7 with stalled output: FIFO fills to DEPTH
      start = 1'b1; len = 3'd7;
      nclk();
      start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0; acc = 0;
      for (int c = 0; c < 7; c++) begin
         bus.in_data = 16'hA000 + 16'(acc);
         if (bus.in_ready) acc++;
         nclk();
      end
      chk("t2_accepted", 32'(acc), 4);
      chk("t2_in_ready_full", 32'(bus.in_ready), 0);
      chk("t2_valid_stall", 32'(bus.out_valid), 1);
      chk("t2_data_stall", 32'(bus.out_data), 32'hA000);
      chk("t2_idx_stall", 32'(bus.out_idx), 0);
      nclk();
      chk("t2_data_hold", 32'(bus.out_data), 32'hA000);
      chk("t2_idx_hold", 32'(bus.out_idx), 0);
      bus.out_ready = 1'b1; got = 0; seen_done = 1'b0;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         bus.in_data = 16'hA000 + 16'(acc);
         if (bus.in_ready) acc++;
         if (bus.out_valid) begin
            chk("t2_data", 32'(bus.out_data), 32'hA000 + 32'(got));
            chk("t2_idx",  32'(bus.out_idx),  32'(got));
            chk("t2_last", 32'(bus.out_last), 32'(got == 6));
            chk("t2_pre",  32'(bus.pre_last), 32'(got == 4));
            got++;
         end
         nclk();
         if (done) seen_done = 1'b1;
      end
      bus.in_valid = 1'b0;
      chk("t2_delivered", 32'(got), 7);
      chk("t2_pushed", 32'(acc), 7);
      chk("t2_done_seen", 32'(seen_done), 1);
      nclk();
      chk("t2_busy_off", 32'(busy), 0);

      // len=0: straight to DONE
      start = 1'b1; len = 3'd0;
      nclk();
      start = 1'b0;
      chk("t3_done", 32'(done), 1);
      chk("t3_busy", 32'(busy), 1);
      chk("t3_in_ready", 32'(bus.in_ready), 0);
      nclk();
      chk("t3_done_off", 32'(done), 0);
      chk("t3_busy_off", 32'(busy), 0);

      // len=2: pre_last never, out_last at idx 1
      start = 1'b1; len = 3'd2;
      nclk();
      start = 1'b0;
      stream(2, 16'h00B0, 16'h0001, 2);
      nclk();
      chk("t4_done", 32'(done), 1);
      nclk();

      // sys_rst mid-job with words still buffered
      start = 1'b1; len = 3'd6;
      nclk();
      start = 1'b0;
      stream(3, 16'h00C0, 16'h0001, 6);
      bus.in_valid = 1'b1; bus.in_data = 16'h00C3;
      nclk();
      chk("t5_data3", 32'(bus.out_data), 32'h00C3);
      chk("t5_idx3", 32'(bus.out_idx), 3);
      bus.out_ready = 1'b0; bus.in_data = 16'h00C4;
      nclk();
      chk("t5_valid_pre_flush", 32'(bus.out_valid), 1);
      sys_rst = 1'b1;
      nclk();
      chk_zero("t5_flush");
      sys_rst = 1'b0; bus.in_valid = 1'b0;
      nclk();
      chk("t5_no_done", 32'(done), 0);
      start = 1'b1; len = 3'd1;
      nclk();
      start = 1'b0;
      stream(1, 16'h00D1, 16'h0001, 1);
      nclk();
      chk("t5_done_len1", 32'(done), 1);
      nclk();

      // start during RUN is ignored: len stays 3
      start = 1'b1; len = 3'd3;
      nclk();
      len = 3'd5;
      nclk();
      start = 1'b0; len = 3'd0;
      stream(3, 16'h00E0, 16'h0001, 3);
      nclk();
      chk("t6_done", 32'(done), 1);
      nclk();

      // async reset mid-job
      start = 1'b1; len = 3'd4;
      nclk();
      start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h00F0; bus.out_ready = 1'b0;
      nclk();
      bus.in_data = 16'h00F1;
      nclk();
      bus.in_valid = 1'b0;
      chk("t7_valid", 32'(bus.out_valid), 1);
      chk("t7_data", 32'(bus.out_data), 32'h00F0);
      #2 reset = 1'b0;
      #1 chk_zero("t7_async");
      #1 reset = 1'b1;
      nclk();
      chk("t7_busy_after", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mxv_result_drain.md
Name: mxv_result_drain

Overview:
- Output-side counterpart of the input element counter in the MxV datapath.
- The input side counts operands into the multiplier. This block collects the LEN results the datapath produces for one matrix-vector job.
- Results are buffered in a small FIFO and drained onto a valid/ready output stream.
- It provides element indexing, a last-element marker, an early pre-last flag and an end-of-job pulse.

Parameters:
- DATA_W, 16: width of one result word.
- MAX_LEN, 7: largest job length supported.
- LEN_W, 3: width of len and out_idx. Must hold MAX_LEN, i.e. LEN_W >= ceil(log2(MAX_LEN+1)).
- DEPTH, 4: FIFO entries. Power of two, >= 2.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- sys_rst, input, 1: synchronous, active-high flush.
- start, input, 1: single-cycle job start; sampled only in IDLE.
- len, input, LEN_W: job length, latched on an accepted start.
- in_valid, input, 1: result word present from the datapath.
- in_data, input, DATA_W: result word.
- in_ready, output, 1: block accepts in_data this cycle.
- out_valid, output, 1: out_data valid.
- out_data, output, DATA_W: head result.
- out_ready, input, 1: downstream accepts this cycle.
- out_last, output, 1: current output word is index len-1.
- pre_last, output, 1: current output index == len-3.
- out_idx, output, LEN_W: index of the current output word within the job.
- busy, output, 1: FSM not IDLE.
- done, output, 1: one-cycle end-of-job pulse.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; FIFO empty; all counters 0; latched len 0. All outputs 0: in_ready, out_valid, out_data, out_last, pre_last, out_idx, busy, done.
- sys_rst=1 (sync, priority over all other inputs): same state as reset on the next edge. Flushes FIFO contents and aborts a job mid-operation. No done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1 with len!=0, latch len, clear in_cnt/out_cnt, go to RUN.
  - IDLE: on start=1 with len==0, go directly to DONE (done pulse, no data moved).
  - RUN: when an output handshake occurs with out_cnt==len-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- Input side:
  - in_ready = (state==RUN) & FIFO not full & (in_cnt < len). Registered-style: no combinational path from out_ready.
  - A push happens when in_valid & in_ready; in_cnt increments.
  - in_valid is ignored in IDLE and DONE, and once len words have been accepted.
- FIFO:
  - DEPTH entries; occupancy counter is width log2(DEPTH)+1.
  - Simultaneous push and pop leaves occupancy unchanged. A pop on a full FIFO frees space on the next cycle only.
- Output side:
  - out_valid = FIFO not empty (state==RUN). out_data = head entry.
  - An output handshake happens when out_valid & out_ready; out_cnt increments.
  - While out_valid=1 and out_ready=0: out_valid, out_data, out_idx, out_last and pre_last hold stable.
- Latency: a word pushed at edge t is presented with out_valid=1 in the cycle after t. Minimum latency 1 cycle; throughput 1 word/cycle.
- out_idx = out_cnt.
- out_last = out_valid & (out_cnt == len-1).
- pre_last = out_valid & (out_cnt == len-3). Evaluate len-3 in LEN_W+1 bits signed so len<3 never asserts pre_last (no wrap).
- Arithmetic: counters are LEN_W bits, never exceed len, never wrap. len > MAX_LEN is undefined use; assertion only.
- busy = (state != IDLE).

Test Plan:
- Reset, then start with len=5. Push 0x11,0x22,0x33,0x44,0x55 back-to-back with out_ready=1 -> outputs appear 1 cycle after each push, out_idx 0..4. pre_last only at idx 2; out_last only at idx 4 (0x55). done pulses 1 cycle after the 0x55 handshake; busy then drops.
- len=7, DEPTH=4, out_ready=0 and in_valid=1 continuous -> exactly 4 words accepted, then in_ready=0. Raising out_ready drains in order; all 7 words delivered; out_data is held stable during the stall.
- start with len=0 -> no in_ready. done=1 the cycle after start; busy=1 for that cycle only.
- len=2 -> pre_last never asserts; out_last at idx 1.
- Assert sys_rst after 3 of 6 outputs -> next cycle: FIFO empty, out_valid=0, busy=0, no done pulse. A new start with len=1 then works normally.
- start while in RUN -> ignored, latched len unchanged. Async reset low mid-job -> outputs are 0 immediately, without waiting for a clock edge.
